// File: rtl/imem_loader_pkg.sv
// ============================================================================
// Module   : imem_loader_pkg
// Brief    : Shared state, error-code and frame constants for the imem loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package imem_loader_pkg;

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } loader_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_SUM  = 2'd2;

  localparam int c_HDR_BYTES = 2;

  // The loader takes stream bytes in every state that still expects frame data.
  function automatic logic isReadyState(input loader_state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
// ============================================================================
// Module   : byte_packer
// Brief    : Big-endian byte-to-word shift register with a one-cycle word flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byteValid,
  input  logic [7:0]  byteData,
  output logic [1:0]  byteIdx,
  output logic        wordValid,
  output logic [31:0] word
);

  logic [31:0] r_shift;
  logic [1:0]  r_idx;
  logic        r_wordValid;

  // The word stays in the shift register during the flag cycle; a byte
  // accepted in that cycle only shifts in at the closing edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift     <= 32'd0;
      r_idx       <= 2'd0;
      r_wordValid <= 1'b0;
    end else if (clear) begin
      r_shift     <= 32'd0;
      r_idx       <= 2'd0;
      r_wordValid <= 1'b0;
    end else begin
      r_wordValid <= byteValid && (r_idx == 2'd3);
      if (byteValid) begin
        r_shift <= {r_shift[23:0], byteData};
        r_idx   <= r_idx + 2'd1;
      end
    end
  end

  assign byteIdx   = r_idx;
  assign wordValid = r_wordValid;
  assign word      = r_shift;

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Brief    : Boot-time instruction-memory writer for length-prefixed frames.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  inValid,
  input  logic [7:0]            inData,
  output logic                  inReady,
  output logic                  imWriteEnable,
  output logic [ADDR_WIDTH-1:0] imAddress,
  output logic [31:0]           imWriteData,
  output logic                  holdCPU,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            errCode,
  output logic [ADDR_WIDTH:0]   wordsWritten
);

  localparam logic [16:0] c_CAPACITY = 17'd1 << ADDR_WIDTH;

  loader_state_t r_state;
  loader_state_t w_nextState;

  logic                r_lenHiValid;
  logic [7:0]          r_lenHi;
  logic [15:0]         r_len;
  logic [15:0]         r_wordsIn;
  logic [7:0]          r_sum;
  logic [1:0]          r_errCode;
  logic [ADDR_WIDTH:0] r_wordsWritten;

  logic        w_xfer;
  logic        w_restart;
  logic        w_setErrLen;
  logic        w_setErrSum;
  logic        w_packByte;
  logic        w_wordValid;
  logic [1:0]  w_byteIdx;
  logic [31:0] w_word;
  logic [15:0] w_lenFull;
  logic        w_lenOverflow;
  logic        w_lastWord;

  assign inReady       = rst & isReadyState(r_state);
  assign w_xfer        = inValid & inReady;
  assign w_lenFull     = {r_lenHi, inData};
  assign w_lenOverflow = {1'b0, w_lenFull} > c_CAPACITY;
  assign w_lastWord    = (r_wordsIn + 16'd1) == r_len;
  assign w_packByte    = w_xfer && (r_state == DATA);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_restart),
    .byteValid (w_packByte),
    .byteData  (inData),
    .byteIdx   (w_byteIdx),
    .wordValid (w_wordValid),
    .word      (w_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LEN_HI;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_restart   = 1'b0;
    w_setErrLen = 1'b0;
    w_setErrSum = 1'b0;
    case (r_state)
      LEN_HI: begin
        if (w_xfer) w_nextState = LEN_LO;
      end
      LEN_LO: begin
        if (w_xfer) begin
          if (w_lenOverflow) begin
            w_nextState = ERR;
            w_setErrLen = 1'b1;
          end else if (w_lenFull == 16'd0) begin
            w_nextState = CHECK;
          end else begin
            w_nextState = DATA;
          end
        end
      end
      DATA: begin
        if (w_xfer && (w_byteIdx == 2'd3) && w_lastWord) w_nextState = CHECK;
      end
      CHECK: begin
        if (w_xfer) begin
          if (inData == r_sum) begin
            w_nextState = DONE;
          end else begin
            w_nextState = ERR;
            w_setErrSum = 1'b1;
          end
        end
      end
      DONE, ERR: begin
        if (start) begin
          w_nextState = LEN_HI;
          w_restart   = 1'b1;
        end
      end
      default: w_nextState = LEN_HI;
    endcase
  end

  // r_wordsIn counts packed words as they complete, ahead of the write strobe,
  // so the final word can move the FSM on without waiting for its write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lenHiValid   <= 1'b0;
      r_lenHi        <= 8'd0;
      r_len          <= 16'd0;
      r_wordsIn      <= 16'd0;
      r_sum          <= 8'd0;
      r_errCode      <= ERR_NONE;
      r_wordsWritten <= '0;
    end else if (w_restart) begin
      r_lenHiValid   <= 1'b0;
      r_lenHi        <= 8'd0;
      r_len          <= 16'd0;
      r_wordsIn      <= 16'd0;
      r_sum          <= 8'd0;
      r_errCode      <= ERR_NONE;
      r_wordsWritten <= '0;
    end else begin
      if (w_xfer && (r_state == LEN_HI)) begin
        r_lenHi      <= inData;
        r_lenHiValid <= 1'b1;
      end
      if (w_xfer && (r_state == LEN_LO)) begin
        r_len <= w_lenFull;
      end
      if (w_packByte) begin
        r_sum <= r_sum ^ inData;
        if (w_byteIdx == 2'd3) r_wordsIn <= r_wordsIn + 16'd1;
      end
      if (w_wordValid) begin
        r_wordsWritten <= r_wordsWritten + (ADDR_WIDTH+1)'(1);
      end
      if (w_setErrLen) begin
        r_errCode <= ERR_LEN;
      end else if (w_setErrSum) begin
        r_errCode <= ERR_SUM;
      end
    end
  end

  assign imWriteEnable = w_wordValid;
  assign imAddress     = r_wordsWritten[ADDR_WIDTH-1:0];
  assign imWriteData   = w_word;
  assign wordsWritten  = r_wordsWritten;
  assign errCode       = r_errCode;
  assign done          = (r_state == DONE);
  assign error         = (r_state == ERR);
  assign holdCPU       = (r_state != DONE);

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed table-driven bench for the instruction-memory loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          inValid = 1'b0;
  logic [7:0]    inData = 8'd0;
  logic          inReady;
  logic          imWriteEnable;
  logic [AW-1:0] imAddress;
  logic [31:0]   imWriteData;
  logic          holdCPU;
  logic          done;
  logic          error;
  logic [1:0]    errCode;
  logic [AW:0]   wordsWritten;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .inValid       (inValid),
    .inData        (inData),
    .inReady       (inReady),
    .imWriteEnable (imWriteEnable),
    .imAddress     (imAddress),
    .imWriteData   (imWriteData),
    .holdCPU       (holdCPU),
    .done          (done),
    .error         (error),
    .errCode       (errCode),
    .wordsWritten  (wordsWritten)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Write log taken on the falling edge; handshake count and adjacency give latency.
  int            negCnt = 0;
  int            hsCnt = 0;
  int            lastHsNeg = -10;
  int            hsBase = 0;
  logic [AW-1:0] wrAddr[$];
  logic [31:0]   wrData[$];
  int            wrHs[$];
  bit            wrAdj[$];

  always @(negedge clk) begin
    if (imWriteEnable) begin
      wrAddr.push_back(imAddress);
      wrData.push_back(imWriteData);
      wrHs.push_back(hsCnt);
      wrAdj.push_back(lastHsNeg == negCnt - 1);
    end
    if (inValid && inReady) begin
      hsCnt     <= hsCnt + 1;
      lastHsNeg <= negCnt;
    end
    negCnt <= negCnt + 1;
  end

  typedef struct {
    string           name;
    int              n;
    logic [0:15][7:0] b;
    bit              tog;
    int              nW;
    logic [31:0]     w0;
    logic [31:0]     w1;
    logic            expDone;
    logic            expErr;
    logic [1:0]      expCode;
    int              expWords;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    wrHs.delete();
    wrAdj.delete();
    hsBase = hsCnt;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit tog);
    inValid = 1'b1;
    inData  = b;
    tick();
    if (tog) begin
      inValid = 1'b0;
      inData  = 8'($urandom);
      tick();
    end
  endtask

  task automatic idle(input int n);
    inValid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, " reset we"},    imWriteEnable, 0);
    check({tag, " reset addr"},  imAddress, 0);
    check({tag, " reset data"},  imWriteData, 0);
    check({tag, " reset done"},  done, 0);
    check({tag, " reset error"}, error, 0);
    check({tag, " reset code"},  errCode, 0);
    check({tag, " reset words"}, wordsWritten, 0);
    check({tag, " reset hold"},  holdCPU, 1);
    check({tag, " reset ready"}, inReady, 0);
  endtask

  task automatic doReset();
    rst     = 1'b0;
    start   = 1'b0;
    inValid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic checkWrites(input string tag, input int nW, input logic [31:0] w0, input logic [31:0] w1);
    logic [31:0] exp;
    check({tag, " write count"}, wrAddr.size(), nW);
    for (int k = 0; k < nW && k < wrAddr.size(); k++) begin
      exp = (k == 0) ? w0 : w1;
      check({tag, " write addr"},    wrAddr[k], k);
      check({tag, " write data"},    wrData[k], exp);
      check({tag, " write latency"}, wrHs[k] - hsBase, 2 + 4 * (k + 1));
      check({tag, " write adjacent"}, wrAdj[k], 1);
    end
  endtask

  task automatic checkResult(input string tag, input logic expDone, input logic expErr,
                             input logic [1:0] expCode, input int expWords);
    check({tag, " done"},  done, expDone);
    check({tag, " error"}, error, expErr);
    check({tag, " code"},  errCode, expCode);
    check({tag, " words"}, wordsWritten, expWords);
    check({tag, " hold"},  holdCPU, !expDone);
    check({tag, " ready"}, inReady, !(expDone || expErr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"ok2", 11, 128'h0002_2001_0005_8C02_0004_AE00_0000_0000, 1'b0, 2,
                32'h20010005, 32'h8C020004, 1'b1, 1'b0, 2'd0, 2};
    vecs[1] = '{"badsum", 11, 128'h0002_2001_0005_8C02_0004_AF00_0000_0000, 1'b0, 2,
                32'h20010005, 32'h8C020004, 1'b0, 1'b1, 2'd2, 2};
    vecs[2] = '{"overflow", 2, 128'h0101_0000_0000_0000_0000_0000_0000_0000, 1'b0, 0,
                32'h0, 32'h0, 1'b0, 1'b1, 2'd1, 0};
    vecs[3] = '{"toggled", 11, 128'h0002_2001_0005_8C02_0004_AE00_0000_0000, 1'b1, 2,
                32'h20010005, 32'h8C020004, 1'b1, 1'b0, 2'd0, 2};
    vecs[4] = '{"len0ok", 3, 128'h0000_0000_0000_0000_0000_0000_0000_0000, 1'b0, 0,
                32'h0, 32'h0, 1'b1, 1'b0, 2'd0, 0};
    vecs[5] = '{"len0bad", 3, 128'h0000_5A00_0000_0000_0000_0000_0000_0000, 1'b0, 0,
                32'h0, 32'h0, 1'b0, 1'b1, 2'd2, 0};

    #1;
    tick();
    checkResetValues("initial");

    for (int i = 0; i < 6; i++) begin
      doReset();
      clearLog();
      for (int j = 0; j < vecs[i].n; j++) sendByte(vecs[i].b[j], vecs[i].tog);
      idle(3);
      checkWrites(vecs[i].name, vecs[i].nW, vecs[i].w0, vecs[i].w1);
      checkResult(vecs[i].name, vecs[i].expDone, vecs[i].expErr, vecs[i].expCode, vecs[i].expWords);
    end

    // Exactly 2^ADDR_WIDTH words is a legal length.
    doReset();
    sendByte(8'h01, 1'b0);
    sendByte(8'h00, 1'b0);
    idle(2);
    check("len256 error", error, 0);
    check("len256 ready", inReady, 1);

    // Reset in the middle of a frame, then a fresh single-word frame.
    doReset();
    sendByte(8'h00, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h20, 1'b0);
    sendByte(8'h01, 1'b0);
    sendByte(8'h00, 1'b0);
    sendByte(8'h05, 1'b0);
    sendByte(8'h8C, 1'b0);
    inValid = 1'b1;
    inData  = 8'h02;
    tick();
    rst = 1'b0;
    #1;
    checkResetValues("midframe");
    inValid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    clearLog();
    sendByte(8'h00, 1'b0);
    sendByte(8'h01, 1'b0);
    repeat (4) sendByte(8'hFF, 1'b0);
    sendByte(8'h00, 1'b0);
    idle(3);
    checkWrites("fresh", 1, 32'hFFFFFFFF, 32'h0);
    checkResult("fresh", 1'b1, 1'b0, 2'd0, 1);

    // Bytes offered in DONE without start are refused.
    clearLog();
    inValid = 1'b1;
    inData  = 8'hAA;
    tick();
    check("done refuse ready", inReady, 0);
    tick();
    tick();
    idle(1);
    check("done refuse writes", wrAddr.size(), 0);
    checkResult("done hold", 1'b1, 1'b0, 2'd0, 1);

    // start from DONE restarts; start held during the header is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    checkResult("restart", 1'b0, 1'b0, 2'd0, 0);
    clearLog();
    start = 1'b1;
    sendByte(8'h00, 1'b0);
    sendByte(8'h00, 1'b0);
    start = 1'b0;
    sendByte(8'h00, 1'b0);
    idle(3);
    check("empty writes", wrAddr.size(), 0);
    checkResult("empty", 1'b1, 1'b0, 2'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time writer for the instruction memory; the datapath's fetch stage is the only reader of that memory. It accepts a byte stream over a valid/ready handshake, parses a length-prefixed frame, packs bytes big-endian into 32-bit words, and writes them to consecutive instruction-memory word addresses starting at 0. It also verifies a trailing XOR checksum. It holds the processor (PC and pipeline) until a frame completes cleanly.

Parameters:
ADDR_WIDTH, 8, instruction-memory word address width; capacity is 2^ADDR_WIDTH words.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
start  in  1  reload request; honoured only in DONE or ERR
inValid  in  1  byte available on inData
inData  in  8  stream byte
inReady  out  1  loader can accept a byte; a byte transfers when inValid & inReady on a clock edge
imWriteEnable  out  1  one-cycle instruction-memory write strobe
imAddress  out  ADDR_WIDTH  word address for the write
imWriteData  out  32  word to write
holdCPU  out  1  1 = keep PC/pipeline held
done  out  1  frame loaded and checksum good
error  out  1  frame rejected
errCode  out  2  0 none, 1 length overflow, 2 checksum mismatch
wordsWritten  out  ADDR_WIDTH+1  count of words written this frame

Behaviour:
- Frame format: LEN_HI, LEN_LO (word count N, big-endian 16 bit), then 4N payload bytes (first byte = bits 31:24), then 1 checksum byte = XOR of all 4N payload bytes. Header bytes are not included in the checksum.
- States: LEN_HI -> LEN_LO -> DATA -> CHECK -> DONE | ERR.
- Reset (rst=0) forces state LEN_HI and the following output values: imWriteEnable 0, imAddress 0, imWriteData 0, done 0, error 0, errCode 0, wordsWritten 0, holdCPU 1. Reset also clears the partial word, byte index and checksum accumulator. Reset mid-frame discards everything in flight.
- inReady is a combinational function of state: 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 in DONE and ERR. While rst=0, inReady is 0.
- LEN_LO transfer:
  - If N > 2^ADDR_WIDTH, go to ERR with errCode 1; no writes occur.
  - If N = 0, go to CHECK.
  - Otherwise go to DATA.
- DATA: a 2-bit byte index counts accepted bytes.
  - On the 4th byte the packed word is registered. On the next cycle imWriteEnable=1 for exactly one cycle with imAddress = current address and imWriteData = word. The address and wordsWritten increment after the strobe.
  - Latency: strobe appears 1 cycle after the 4th byte's handshake edge.
  - After the Nth word is accepted, go to CHECK. Bytes can continue to arrive during the strobe cycle.
- CHECK: accepted byte == accumulator -> DONE (done=1, holdCPU=0). Mismatch -> ERR (error=1, errCode=2, holdCPU stays 1). Words already written are left in memory.
- Cycles with inValid=0 change nothing; inData is ignored.
- The address never wraps, because N is bounded by the overflow check.
- start in DONE/ERR: next state LEN_HI; clears done, error, errCode, address, wordsWritten and checksum; holdCPU returns to 1. start in any other state is ignored.
- holdCPU = 1 in every state except DONE.

Decomposition:
- Shared package holds:
  - state encoding constants (LEN_HI, LEN_LO, DATA, CHECK, DONE, ERR);
  - errCode constants (ERR_NONE=0, ERR_LEN=1, ERR_SUM=2);
  - header byte count (2).
- One sub-module: byte_packer. It is a 32-bit shift register plus 2-bit byte index and emits wordValid on the 4th byte. It has a clear input driven by start and rst.

Test Plan:
1. Frame 00 02 | 20 01 00 05 | 8C 02 00 04 | AE -> strobes addr0=0x20010005 and addr1=0x8C020004; then done=1, holdCPU=0, wordsWritten=2, error=0.
2. Same frame with checksum AF -> both writes occur; error=1, errCode=2, done=0, holdCPU=1, inReady=0.
3. Header 01 01 (N=257, ADDR_WIDTH=8) -> ERR after the 2nd byte, errCode=1; no imWriteEnable pulses.
4. Frame from test 1 with inValid toggled every other cycle and garbage on inData when invalid -> identical writes and result; each strobe is 1 cycle after its 4th byte.
5. rst pulled low after 6 payload bytes of test 1 -> all outputs at reset values. A subsequent fresh frame 00 01 | FF FF FF FF | 00 writes 0xFFFFFFFF at addr 0 and sets done.
6. From DONE, pulse start, then send frame 00 00 | 00 -> no writes, done=1, wordsWritten=0. Inputs sent while in DONE without start -> inReady=0, no effect.
